// File: rtl/bloco_operacional.sv
// -----------------------------------------------------------------------------
// bloco_operacional
//
// Datapath stage driven by the control block. Holds a NREGS x DATA_W register
// file with two combinational read ports (P and Q), a 3-way write-data mux,
// a pass/add/sub ALU and a registered carry/overflow status pair.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset        - asynchronous, active-high reset (clears registers and flags)
//   D_rdata      - data memory read data (MOVR source)
//   D_wdata      - data memory write data (port P read data)
//   RF_W_data    - instruction constant (MOVC source)
//   RF_s0/RF_s1  - write-mux select {RF_s1, RF_s0}: 00 ALU, 01 mem, 10 const
//   RF_W_addr    - write address
//   RF_W_wr      - write enable
//   RF_Rp_addr   - port P read address
//   RF_Rp_rd     - port P read enable (disabled port reads as 0)
//   RF_Rq_addr   - port Q read address
//   RF_Rq_rd     - port Q read enable (disabled port reads as 0)
//   alu_s0/1     - ALU op {alu_s1, alu_s0}: 00 pass, 01 add, 10 sub
//   RF_Rp_zero   - port P enabled and its read data is zero (same cycle)
//   alu_carry    - carry/borrow of the last ADD/SUB written back
//   alu_overflow - signed overflow of the last ADD/SUB written back
// -----------------------------------------------------------------------------
module bloco_operacional #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] D_rdata,
    output logic [DATA_W-1:0] D_wdata,
    input  logic [DATA_W-1:0] RF_W_data,
    input  logic              RF_s0,
    input  logic              RF_s1,
    input  logic [ADDR_W-1:0] RF_W_addr,
    input  logic              RF_W_wr,
    input  logic [ADDR_W-1:0] RF_Rp_addr,
    input  logic              RF_Rp_rd,
    input  logic [ADDR_W-1:0] RF_Rq_addr,
    input  logic              RF_Rq_rd,
    input  logic              alu_s0,
    input  logic              alu_s1,
    output logic              RF_Rp_zero,
    output logic              alu_carry,
    output logic              alu_overflow
);

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_RSVD = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL_ALU   = 2'b00,
        SEL_MEM   = 2'b01,
        SEL_CONST = 2'b10,
        SEL_RSVD  = 2'b11
    } wr_sel_t;

    logic [DATA_W-1:0] regs [NREGS];

    logic [DATA_W-1:0] rp_data;
    logic [DATA_W-1:0] rq_data;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c;
    logic              alu_v;
    logic [DATA_W-1:0] w_data;
    logic              w_en;
    logic              flags_en;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;

    alu_op_t alu_op;
    wr_sel_t wr_sel;

    assign alu_op = alu_op_t'({alu_s1, alu_s0});
    assign wr_sel = wr_sel_t'({RF_s1, RF_s0});

    // Read ports: a disabled port drives 0 so the ALU and RF_Rp_zero never see X.
    assign rp_data = RF_Rp_rd ? regs[RF_Rp_addr] : '0;
    assign rq_data = RF_Rq_rd ? regs[RF_Rq_addr] : '0;

    // The control FSM samples this in the same cycle, so it must stay combinational.
    assign RF_Rp_zero = RF_Rp_rd && (rp_data == '0);
    assign D_wdata    = rp_data;

    // One extra bit holds the carry out of ADD and the borrow out of SUB.
    assign sum_ext  = {1'b0, rp_data} + {1'b0, rq_data};
    assign diff_ext = {1'b0, rp_data} - {1'b0, rq_data};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_op)
            ALU_PASS: alu_result = rp_data;
            ALU_ADD: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_c      = sum_ext[DATA_W];
                // Same-sign operands producing a result of the other sign.
                alu_v      = (rp_data[DATA_W-1] == rq_data[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != rp_data[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_c      = diff_ext[DATA_W];
                // Opposite-sign operands where the result sign departs from Rp.
                alu_v      = (rp_data[DATA_W-1] != rq_data[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != rp_data[DATA_W-1]);
            end
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        w_data = '0;
        case (wr_sel)
            SEL_ALU:   w_data = alu_result;
            SEL_MEM:   w_data = D_rdata;
            SEL_CONST: w_data = RF_W_data;
            default:   w_data = '0;
        endcase
    end

    // The reserved mux code suppresses the write regardless of RF_W_wr.
    assign w_en     = RF_W_wr && (wr_sel != SEL_RSVD);
    assign flags_en = RF_W_wr && (wr_sel == SEL_ALU) &&
                      ((alu_op == ALU_ADD) || (alu_op == ALU_SUB));

    // NOTE: the register array is cleared by reset because the control block
    // relies on every register reading zero after reset; this keeps it in
    // flops rather than a RAM macro, which is acceptable at this size.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together on the edge and reads in the same cycle see old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[RF_W_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_carry    <= 1'b0;
            alu_overflow <= 1'b0;
        end else if (flags_en) begin
            alu_carry    <= alu_c;
            alu_overflow <= alu_v;
        end
    end

endmodule

// File: doc/bloco_operacional.md
Name: bloco_operacional

Overview:
- Datapath stage directly downstream of the control block. It consumes every RF_*/alu_* control signal and produces RF_Rp_zero back to it.
- Contains a 16x8 register file, a 3-way write-data mux, a pass/add/sub ALU and a registered carry/overflow status pair.
- Exchanges data with the external data memory: read data in, write data out. The memory is addressed by the control block.

Parameters:
DATA_W, 8, datapath and register width
NREGS, 16, number of registers in the register file
ADDR_W, 4, register address width (log2 NREGS)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
D_rdata  input  DATA_W  data memory read data
D_wdata  output  DATA_W  data memory write data
RF_W_data  input  DATA_W  constant from instruction (MOVC path)
RF_s0  input  1  write-mux select bit 0
RF_s1  input  1  write-mux select bit 1
RF_W_addr  input  ADDR_W  write address
RF_W_wr  input  1  write enable
RF_Rp_addr  input  ADDR_W  port P read address
RF_Rp_rd  input  1  port P read enable
RF_Rq_addr  input  ADDR_W  port Q read address
RF_Rq_rd  input  1  port Q read enable
alu_s0  input  1  ALU op bit 0
alu_s1  input  1  ALU op bit 1
RF_Rp_zero  output  1  port P read data equals zero
alu_carry  output  1  registered carry/borrow of last ADD/SUB writeback
alu_overflow  output  1  registered signed overflow of last ADD/SUB writeback

Behaviour:
- Reset (async, active-high): all NREGS registers, alu_carry and alu_overflow go to 0 immediately. Combinational outputs follow from the cleared state.
- Read ports are combinational:
  - Rp_data = RF_Rp_rd ? reg[RF_Rp_addr] : 0. Rq_data likewise with RF_Rq_rd/RF_Rq_addr.
  - Disabled ports drive 0, never X or Z.
- RF_Rp_zero = RF_Rp_rd & (Rp_data == 0). It is combinational with zero latency, because the control FSM samples it in the same cycle to choose its next state.
- D_wdata = Rp_data, combinational.
- ALU, combinational, op = {alu_s1, alu_s0}:
  - 00: result = Rp_data (pass).
  - 01: result = Rp_data + Rq_data, modulo 2^DATA_W. carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - 10: result = Rp_data - Rq_data, modulo 2^DATA_W. carry = borrow, i.e. 1 when Rp < Rq unsigned.
  - 11: reserved; result = 0.
  - Overflow is two's-complement: add = operands same sign and result sign differs; sub = operands differ in sign and result sign differs from Rp.
- Write mux, sel = {RF_s1, RF_s0}:
  - 00: ALU result.
  - 01: D_rdata.
  - 10: RF_W_data.
  - 11: reserved; the write is suppressed even if RF_W_wr=1.
- Write: on rising clk with RF_W_wr=1 and sel != 11, reg[RF_W_addr] <= mux output. Write latency is 1 cycle. All registers, including r0, are writable.
- Read-during-write to the same address returns the OLD value in that cycle; the new value is visible from the next cycle. There is no bypass.
- Status update:
  - On rising clk with RF_W_wr=1, sel=00 and op in {01,10}, alu_carry and alu_overflow load the ALU carry/overflow.
  - Otherwise they hold their value. Pass, MOVR, MOVC and store cycles do not alter them.
- No internal FSM. Sequencing is owned by the control block; this block only guarantees single-cycle read/execute/write per control state.
- Reset mid-operation: a write pending on the same edge as reset assertion is discarded. Registers stay 0 while reset is high.

Test Plan:
- Reset then read all 16 registers on both ports with rd=1 -> every read returns 0x00; RF_Rp_zero=1, alu_carry=0, alu_overflow=0.
- MOVC r3<-0x7F (sel=10, W_addr=3, W_data=0x7F, wr=1), then Rp_addr=3, rd=1 next cycle -> Rp_data 0x7F, RF_Rp_zero=0. In the write cycle itself, Rp of r3 returns 0x00.
- r1=0x7F, r2=0x01; ADD r4=r1+r2 (sel=00, alu=01) -> r4=0x80, carry=0, overflow=1 after the edge.
- With r1=0x7F, r2=0x01: SUB r5=r2-r1 -> r5=0x82, carry(borrow)=1, overflow=0. A following MOVC leaves both flags unchanged.
- MOVR r6<-D_rdata=0xA5 (sel=01) -> r6=0xA5. Store cycle with Rp_addr=6, rd=1 -> D_wdata=0xA5. With rd=0, D_wdata=0x00 and RF_Rp_zero=0.
- sel=11 with wr=1 to r3 -> r3 unchanged. Assert reset asynchronously between clock edges -> all registers and flags read 0 before the next clk edge.
